// File: rtl/mem_pkg.sv
// Shared types and constants for the line-granular backing data memory.
package mem_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    // Counter preload for a given latency: the BUSY phase counts down to zero.
    function automatic logic [CNT_W-1:0] latency_load(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// Line storage: synchronous write, synchronous read with read-enable.
// The read register holds its value between reads and is the module's read data.
module data_memory_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [LINE_W-1:0] mem_q [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    // Array contents are deliberately not reset; only the write port touches them.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register clears on reset and otherwise only changes on a read.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Backing data memory below the L1 data cache: one 256-bit line read or write
// per request, fixed access latency, single-cycle acknowledge.
//
// Handshake: the requester raises enable_i (with addr_i/data_i/write_i) and
// holds it until it sees ack_o. The request is captured on the first rising
// edge in IDLE with enable_i high; inputs are ignored afterwards. ack_o is high
// for exactly one cycle, LATENCY edges after the capture edge, and is always
// followed by at least one IDLE cycle, so an enable_i still high after the ack
// cycle is taken as a new request.
module data_memory
    import mem_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int ADDR_W  = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic [1:0]        state_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = latency_load(LATENCY);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  idx_q;
    logic [LINE_W-1:0]  wdata_q;
    logic               wr_q;

    logic               capture;
    logic               commit;
    logic               mem_we;
    logic               mem_re;

    // Offset bits and index bits above the array depth are intentionally dropped.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:ADDR_W+OFFSET_W], addr_i[OFFSET_W-1:0]};

    assign capture = (state_q == IDLE) && enable_i;
    assign commit  = (state_q == BUSY) && (cnt_q == '0);

    // State register and latency counter; reset drops any in-flight request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture: index, write data and direction are frozen at the capture edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (capture) begin
            idx_q   <= addr_i[ADDR_W+OFFSET_W-1:OFFSET_W];
            wdata_q <= data_i;
            wr_q    <= write_i;
        end
    end

    // Next-state logic. Every latency, including 1, passes through BUSY so that
    // ack_o always lands LATENCY edges after the capture edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only; the array access happens on
    // the BUSY->ACK edge so the write is committed before ack_o rises.
    always_comb begin
        ack_o   = (state_q == ACK);
        state_o = state_q;
        mem_we  = commit && wr_q;
        mem_re  = commit && !wr_q;
    end

    data_memory_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (data_o)
    );

endmodule
